aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_if.sv | 23 ++
 rtl/aes_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Handshake and sequencing bundle between the AES round controller and its neighbours.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [3:0] key_round;
  logic       st_load;
  logic       st_en;
  logic       st_final;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    output in_valid, mode, out_ready,
    input  in_ready, key_round, st_load, st_en, st_final, out_valid, busy
  );

  modport slave (
    input  in_valid, mode, out_ready,
    output in_ready, key_round, st_load, st_en, st_final, out_valid, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: issues round-key indices and state-register strobes.
// Decrypt sequencing is enabled by defining AES_ROUND_CTRL_DECRYPT_EN.
module aes_round_ctrl #(
  parameter int KEY_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    LOAD     = 3'd2,
    ROUND    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] PF_LAST = 2'(KEY_LAT - 1);

  state_t     state_r;
  logic       dec_r;
  logic [1:0] pf_cnt_r;
  logic [3:0] rnd_cnt_r;
  logic [3:0] key_round_r;
  logic       in_ready_r;
  logic       busy_r;
  logic       st_load_r;
  logic       st_en_r;
  logic       st_final_r;
  logic       out_valid_r;
  logic       dec_req_s;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
  assign dec_req_s = bus.mode;
`else
  assign dec_req_s = bus.mode & 1'b0;
`endif

  // Next round-key index, saturating at the far end of the schedule.
  function automatic logic [3:0] step_key(input logic [3:0] k, input logic dec);
    logic [3:0] n;
    if (dec) begin
      n = (k == 4'd0) ? 4'd0 : k - 4'd1;
    end else begin
      n = (k >= 4'd10) ? 4'd10 : k + 4'd1;
    end
    return n;
  endfunction

  // Sequencing FSM with all outputs registered. Key index advances from the
  // second busy cycle so the key used by LOAD/ROUND lags it by KEY_LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      dec_r       <= 1'b0;
      pf_cnt_r    <= 2'd0;
      rnd_cnt_r   <= 4'd0;
      key_round_r <= 4'd0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      st_load_r   <= 1'b0;
      st_en_r     <= 1'b0;
      st_final_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            dec_r       <= dec_req_s;
            key_round_r <= dec_req_s ? 4'd10 : 4'd0;
            pf_cnt_r    <= 2'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= PREFETCH;
          end else begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        PREFETCH: begin
          key_round_r <= step_key(key_round_r, dec_r);
          if (pf_cnt_r == PF_LAST) begin
            st_load_r <= 1'b1;
            state_r   <= LOAD;
          end else begin
            pf_cnt_r  <= pf_cnt_r + 2'd1;
          end
        end
        LOAD: begin
          key_round_r <= step_key(key_round_r, dec_r);
          st_load_r   <= 1'b0;
          st_en_r     <= 1'b1;
          st_final_r  <= 1'b0;
          rnd_cnt_r   <= 4'd1;
          state_r     <= ROUND;
        end
        ROUND: begin
          key_round_r <= step_key(key_round_r, dec_r);
          if (rnd_cnt_r == 4'd10) begin
            st_en_r     <= 1'b0;
            st_final_r  <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            rnd_cnt_r   <= rnd_cnt_r + 4'd1;
            st_final_r  <= (rnd_cnt_r == 4'd9);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          st_load_r   <= 1'b0;
          st_en_r     <= 1'b0;
          st_final_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.key_round = key_round_r;
  assign bus.st_load   = st_load_r;
  assign bus.st_en     = st_en_r;
  assign bus.st_final  = st_final_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (KEY_LAT 1 and 3) driven in lockstep against a timeline model.
module tb_aes_round_ctrl;

  localparam bit DEC_EN =
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  aes_round_ctrl_if bus0 ();
  aes_round_ctrl_if bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.mode      = mode;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.mode      = mode;
  assign bus1.out_ready = out_ready;

  aes_round_ctrl #(.KEY_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  aes_round_ctrl #(.KEY_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int lat [2] = '{1, 3};
  bit m_act [2] = '{1'b0, 1'b0};
  bit m_dec [2] = '{1'b0, 1'b0};
  int m_acc [2] = '{0, 0};
  int m_ikey [2] = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model timeline: offset t from the acceptance cycle fixes every output.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i]  = 1'b0;
        m_ikey[i] = 0;
      end else if (!m_act[i]) begin
        if (in_valid) begin
          m_act[i] = 1'b1;
          m_acc[i] = cyc;
          m_dec[i] = mode & DEC_EN;
        end
      end else if ((cyc - m_acc[i]) >= 12 + lat[i] && out_ready) begin
        m_act[i]  = 1'b0;
        m_ikey[i] = m_dec[i] ? 0 : 10;
      end
    end
    cyc++;
  end

  function automatic logic [9:0] exp_vec(input int i);
    int t;
    int k;
    logic [9:0] v;
    if (rst) begin
      v = 10'b0;
    end else if (!m_act[i]) begin
      v = {1'b1, 1'b0, 4'(m_ikey[i]), 4'b0};
    end else begin
      t = cyc - m_acc[i];
      k = (t - 1 > 10) ? 10 : t - 1;
      if (m_dec[i]) k = 10 - k;
      v = {1'b0, 1'b1, 4'(k),
           1'(t == 1 + lat[i]),
           1'((t >= 2 + lat[i]) && (t <= 11 + lat[i])),
           1'(t == 11 + lat[i]),
           1'(t >= 12 + lat[i])};
    end
    return v;
  endfunction

  // Compare both instances against the model every cycle; in_ready is masked while rst is high.
  always @(negedge clk) begin
    logic [9:0] mask;
    mask = rst ? 10'b10_0000_0000 : 10'b0;
    check("dut0_outputs",
          int'({bus0.in_ready, bus0.busy, bus0.key_round, bus0.st_load, bus0.st_en, bus0.st_final, bus0.out_valid} | mask),
          int'(exp_vec(0) | mask));
    check("dut1_outputs",
          int'({bus1.in_ready, bus1.busy, bus1.key_round, bus1.st_load, bus1.st_en, bus1.st_final, bus1.out_valid} | mask),
          int'(exp_vec(1) | mask));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus0.busy || bus1.busy) && n < 100) begin
      tick();
      n++;
    end
    if (bus0.busy || bus1.busy) begin
      bad++;
      total++;
      $display("FAIL wait_idle: busy still %0d%0d after %0d cycles", bus0.busy, bus1.busy, n);
    end
  endtask

  // One block with out_ready high; checks rise offsets and the dut0 final-round key index.
  task automatic run_block(input bit m, input int exp_key12);
    int acc;
    int r0;
    int r1;
    r0 = -1;
    r1 = -1;
    mode = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc = cyc - 1;
    for (int n = 0; n < 40 && !(r0 >= 0 && r1 >= 0); n++) begin
      @(negedge clk);
      if (cyc - acc == 2) check("dut0_key_t2", int'(bus0.key_round), (m && DEC_EN) ? 9 : 1);
      if (cyc - acc == 12) begin
        check("dut0_final_t12", int'(bus0.st_final), 1);
        check("dut0_key_t12", int'(bus0.key_round), exp_key12);
      end
      if (bus0.out_valid && r0 < 0) r0 = cyc - acc;
      if (bus1.out_valid && r1 < 0) r1 = cyc - acc;
    end
    check("dut0_out_valid_offset", r0, 13);
    check("dut1_out_valid_offset", r1, 15);
    wait_idle();
  endtask

  initial begin
    int acc;
    int cnt;
    int n;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(bus0.in_ready), 1);
    check("reset_busy", int'(bus0.busy), 0);
    check("reset_key", int'(bus0.key_round), 0);
    tick();

    run_block(1'b0, 10);
    run_block(1'b1, DEC_EN ? 0 : 10);

    // Backpressure: out_ready low 5 cycles after the rise, in_valid held high.
    out_ready = 1'b0;
    mode = 1'b0;
    in_valid = 1'b1;
    tick();
    n = 0;
    @(negedge clk);
    while (!bus0.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_rise_seen", int'(bus0.out_valid), 1);
    cnt = 1;
    repeat (5) begin
      tick();
      @(negedge clk);
      if (bus0.out_valid) cnt++;
      check("bp_in_ready_low", int'(bus0.in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_out_valid_cycles", cnt, 6);
    check("bp_out_valid_dropped", int'(bus0.out_valid), 0);
    tick();
    in_valid = 1'b0;
    wait_idle();

    // Reset during ROUND cycle 5 of dut0.
    mode = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc = cyc - 1;
    repeat (6) tick();
    check("rst_mid_round_pos", cyc - acc, 7);
    rst = 1'b1;
    #1;
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_st_en", int'(bus0.st_en), 0);
    check("rst_key", int'(bus0.key_round), 0);
    check("rst_out_valid", int'(bus1.out_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    run_block(1'b0, 10);

    // Back-to-back decrypt requests with in_valid held high.
    mode = 1'b1;
    in_valid = 1'b1;
    repeat (40) tick();
    in_valid = 1'b0;
    wait_idle();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
